// File: rtl/rv_pkg.sv
// Shared writeback definitions: default widths, register count, FIFO entry
// layout and the register-index one-hot helper.
package rv_pkg;

    localparam int RV_DATA_W    = 32;
    localparam int RV_ADDR_W    = 5;
    localparam int RV_REG_COUNT = 32;

    typedef struct packed {
        logic [RV_ADDR_W-1:0] addr;
        logic [RV_DATA_W-1:0] data;
        logic                 kill;
    } wb_entry_t;

    function automatic logic [RV_REG_COUNT-1:0] addr_onehot(input logic [RV_ADDR_W-1:0] a);
        logic [RV_REG_COUNT-1:0] v;
        v    = {RV_REG_COUNT{1'b0}};
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending secondary writes. Entries can be killed in place by
// address match, and the live entries are reported as a register one-hot vector.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  wb_entry_t                 push_entry,
    input  logic                      pop,
    input  logic                      kill_en,
    input  logic [RV_ADDR_W-1:0]      kill_addr,
    output wb_entry_t                 head,
    output logic [$clog2(DEPTH):0]    count,
    output logic [RV_REG_COUNT-1:0]   live_onehot
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t         mem_q [DEPTH];
    wb_entry_t         mem_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [PW:0]       count_q, count_d;
    logic [DEPTH-1:0]  occ_s;
    logic [RV_REG_COUNT-1:0] live_s;

    // Slot occupancy derived from the head pointer and count.
    always_comb begin
        logic [PW-1:0] off;
        off = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off      = PW'(i) - head_q;
            occ_s[i] = ({1'b0, off} < count_q);
        end
    end

    // Kill marking, enqueue at tail, dequeue at head.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ_s[i] && ((kill_en && (mem_q[i].addr == kill_addr)) ||
                             (push && (mem_q[i].addr == push_entry.addr)))) begin
                mem_d[i].kill = 1'b1;
            end else begin
                mem_d[i].kill = mem_q[i].kill;
            end
        end
        // The tail slot is never occupied when a push is allowed, so this wins cleanly.
        if (push) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + 1'b1;
        end else begin
            tail_d = tail_q;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end else begin
            head_d = head_q;
        end
        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {(PW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {$bits(wb_entry_t){1'b0}};
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // One-hot of every occupied, non-killed entry.
    always_comb begin
        live_s = {RV_REG_COUNT{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (occ_s[i] && !mem_q[i].kill) begin
                live_s = live_s | addr_onehot(mem_q[i].addr);
            end else begin
                live_s = live_s;
            end
        end
        live_s[0] = 1'b0;
    end

    assign head        = mem_q[head_q];
    assign count       = count_q;
    assign live_onehot = live_s;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port controller: merges the in-order primary result with
// buffered long-latency writes and publishes a pending-write scoreboard.
module regfile_writeback
    import rv_pkg::*;
#(
    parameter int DATA_W = RV_DATA_W,
    parameter int ADDR_W = RV_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      p_valid,
    input  logic [ADDR_W-1:0]         p_addr,
    input  logic [DATA_W-1:0]         p_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [ADDR_W-1:0]         s_addr,
    input  logic [DATA_W-1:0]         s_data,
    output logic                      WE3,
    output logic [ADDR_W-1:0]         A3,
    output logic [DATA_W-1:0]         WD3,
    output logic [RV_REG_COUNT-1:0]   busy,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                    p_req_s;
    logic                    s_push_s;
    logic                    pop_s;
    wb_entry_t               push_entry_s;
    wb_entry_t               head_s;
    logic [CW-1:0]           count_s;
    logic [RV_REG_COUNT-1:0] live_s;
    logic [RV_REG_COUNT-1:0] busy_s;

    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       a_q, a_d;
    logic [DATA_W-1:0]       wd_q, wd_d;

    // Ready depends only on the registered count, never on this cycle's pop.
    assign s_ready = !rst && (count_s < CW'(DEPTH));

    // Request qualification: register 0 writes vanish from both sources.
    always_comb begin
        p_req_s           = p_valid && (p_addr != {ADDR_W{1'b0}});
        s_push_s          = s_valid && s_ready && (s_addr != {ADDR_W{1'b0}});
        push_entry_s.addr = s_addr;
        push_entry_s.data = s_data;
        push_entry_s.kill = p_req_s && (p_addr == s_addr);
        pop_s             = !p_req_s && (count_s != {CW{1'b0}});
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (s_push_s),
        .push_entry  (push_entry_s),
        .pop         (pop_s),
        .kill_en     (p_req_s),
        .kill_addr   (p_addr),
        .head        (head_s),
        .count       (count_s),
        .live_onehot (live_s)
    );

    // Output slot selection: primary first, then FIFO head; killed heads pop silently.
    always_comb begin
        we_d = 1'b0;
        a_d  = a_q;
        wd_d = wd_q;
        if (p_req_s) begin
            we_d = 1'b1;
            a_d  = p_addr;
            wd_d = p_data;
        end else if (pop_s) begin
            if (!head_s.kill) begin
                we_d = 1'b1;
                a_d  = head_s.addr;
                wd_d = head_s.data;
            end else begin
                we_d = 1'b0;
            end
        end else begin
            we_d = 1'b0;
        end
    end

    // Write-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q <= 1'b0;
            a_q  <= {ADDR_W{1'b0}};
            wd_q <= {DATA_W{1'b0}};
        end else begin
            we_q <= we_d;
            a_q  <= a_d;
            wd_q <= wd_d;
        end
    end

    // Scoreboard: live queued writes plus the write currently on the port.
    always_comb begin
        busy_s = live_s;
        if (we_q) begin
            busy_s = busy_s | addr_onehot(a_q);
        end else begin
            busy_s = busy_s;
        end
        busy_s[0] = 1'b0;
    end

    assign WE3        = we_q;
    assign A3         = a_q;
    assign WD3        = wd_q;
    assign busy       = busy_s;
    assign fifo_count = count_s;

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side controller for the core's 32x32 register file. It merges two writeback sources into the single write port (WE3/A3/WD3). The primary source is the in-order pipeline result: every cycle, highest priority, no backpressure. The secondary source is long-latency units (load, multi-cycle ALU): valid/ready, buffered in a small FIFO. It resolves write-after-write ordering and exports a per-register pending-write scoreboard to the hazard unit.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width
- DEPTH, 4, secondary FIFO entries (power of two, >=2)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- p_valid  in  1  primary write request this cycle
- p_addr  in  ADDR_W  primary destination register
- p_data  in  DATA_W  primary write data
- s_valid  in  1  secondary write request
- s_ready  out  1  secondary request accepted when s_valid && s_ready at an edge
- s_addr  in  ADDR_W  secondary destination register
- s_data  in  DATA_W  secondary write data
- WE3  out  1  register file write enable (registered)
- A3  out  ADDR_W  register file write address (registered)
- WD3  out  DATA_W  register file write data (registered)
- busy  out  32  bit r = a write to register r is queued or in the output slot
- fifo_count  out  clog2(DEPTH)+1  live plus killed entries held

## Operation
- Writes to register 0 are dropped from both sources.
  - Primary: p_valid with p_addr==0 is treated as no request.
  - Secondary: accepted (handshake completes), not stored.
- FIFO entries hold {addr, data, kill}.
- At most one live (kill=0) entry exists per register:
  - When an entry for register r is enqueued, any existing live entry for r is marked kill=1.
  - A primary write to r marks any live entry for r kill=1. The primary result is program-order newer.
- Same edge, p and s both target r (r!=0): the s entry is enqueued already killed.
- Output slot selection each edge, in priority order:
  1. Valid primary request → WE3=1, A3=p_addr, WD3=p_data.
  2. Otherwise, if FIFO is non-empty, pop the head.
     - Live head → WE3=1 with its addr/data.
     - Killed head → WE3=0 (discarded; consumes the pop).
  3. Otherwise WE3=0; A3/WD3 hold their previous values.
- At most one pop per edge. Enqueue and pop may occur on the same edge.
- s_ready = !rst && (count < DEPTH), from registered state only; no combinational path from the pop decision.
- busy = OR over live entries of onehot(addr), OR (WE3 ? onehot(A3) : 0). busy[0] is always 0.

## Timing
- Reset (rst high at an edge) clears:
  - WE3=0, A3=0, WD3=0
  - FIFO empty (fifo_count=0), all kill bits 0, busy=0
  - s_ready=0 while rst is high
- Reset mid-operation discards all queued writes; no WE3 pulse follows.
- Primary latency: request in cycle t → WE3 high in cycle t+1 → register file updated at the end of t+1.
- Secondary minimum latency: handshake at end of cycle t → head available in t+1 → WE3 high in t+2, if no primary request in t+1.
- Secondary starvation is permitted while primary requests are continuous. The FIFO fills and s_ready drops.
- busy[r] rises the cycle after the enqueue edge (or the primary request edge). It falls the cycle after the write-port cycle ends.
- Full with no pop: s_ready=0; s_valid is ignored and must be held by the source.

## Structure
- Shared package `rv_pkg`: DATA_W/ADDR_W defaults, REG_COUNT=32, wb_entry_t typedef {addr, data, kill}.
- One sub-module, `wb_fifo`:
  - circular buffer: head/tail pointers, count
  - per-entry kill-set port, indexed by address match
  - live-address onehot vector output
- Top level holds the arbitration, the output slot, and busy composition.

## Test plan
- Reset, then idle → WE3=0, A3=0, WD3=0, busy=0, s_ready=1, fifo_count=0.
- Primary p_addr=5, p_data=0xA5 for one cycle → next cycle WE3=1, A3=5, WD3=0xA5, busy[5]=1; cycle after that, busy=0.
- Four secondary writes (regs 1..4) with continuous primary to reg 9 → s_ready=0 after 4 handshakes. Drop primary → regs 1..4 written in order, one per cycle.
- Secondary reg 7 = 0x11 queued, then primary reg 7 = 0x22 → WE3 writes 0x22 only; the killed pop gives WE3=0; busy[7] clears.
- Secondary reg 0 and primary reg 0 → WE3 never asserts; handshake completes; fifo_count stays 0.
- Three entries queued, rst asserted for one edge → next cycle fifo_count=0, busy=0, no later WE3 pulse.
